// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants and helpers for the seven-segment scanner
package seg_scan_pkg;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Segment order {a,b,c,d,e,f,g,dp}; entry n is the glyph for nibble n.
   localparam logic [15:0][7:0] HEX_SEG = {
      8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
   };

   function automatic int unsigned cnt_width(input int unsigned range);
      return (range <= 1) ? 1 : $clog2(range);
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - display-update bus between the note/score logic and the scanner
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 8
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   digits_in;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic [NUM_DIGITS-1:0]     blank_in;
   logic                      upd_pending;

   modport master (
      output load, digits_in, dp_in, blank_in,
      input  upd_pending
   );

   modport slave (
      input  load, digits_in, dp_in, blank_in,
      output upd_pending
   );
endinterface

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble plus decimal point to segment pattern
module seg_hex_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   output logic [7:0] pattern_o
);

   assign pattern_o = HEX_SEG[nibble_i] | {7'b0, dp_i};

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered multiplexed seven-segment scanner over two segment buses
// Optional duty-cycle dimming with `define SEG_SCAN_BRIGHTNESS_EN (adds the bright port).
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int GROUP_SIZE = 4,
   parameter int SCAN_DIV   = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seg_scan_ctrl_if.slave        upd,
`ifdef SEG_SCAN_BRIGHTNESS_EN
   input  logic [3:0]            bright,
`endif
   output logic                  frame_done,
   output logic [NUM_DIGITS-1:0] seg_en,
   output logic [7:0]            seg_out0,
   output logic [7:0]            seg_out1
);

   localparam int unsigned DIV_W = cnt_width(SCAN_DIV);
   localparam int unsigned IDX_W = cnt_width(NUM_DIGITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [31:0]      GROUP_U  = 32'(GROUP_SIZE);

   typedef logic [NUM_DIGITS-1:0][3:0] nib_t;
   typedef logic [NUM_DIGITS-1:0]      flag_t;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   nib_t             pend_dig_q, pend_dig_d, shd_dig_q, shd_dig_d;
   flag_t            pend_dp_q, pend_dp_d, shd_dp_q, shd_dp_d;
   flag_t            pend_blank_q, pend_blank_d, shd_blank_q, shd_blank_d;
   logic             upd_pending_q, upd_pending_d;
   flag_t            seg_en_q, seg_en_d;
   logic [7:0]       seg_out0_q, seg_out0_d, seg_out1_q, seg_out1_d;

   logic             tick, last_digit, boundary;
   logic             duty_ok, lit, owner_hi;
   logic [7:0]       dec_pat;

   assign tick       = (div_cnt_q == DIV_LAST);
   assign last_digit = (idx_q == IDX_LAST);
   assign boundary   = tick & last_digit;

   seg_hex_decode u_dec (
      .nibble_i  (shd_dig_q[idx_q]),
      .dp_i      (shd_dp_q[idx_q]),
      .pattern_o (dec_pat)
   );

`ifdef SEG_SCAN_BRIGHTNESS_EN
   logic [36:0] duty_lhs, duty_rhs;

   // bright is taken live so dimming responds within the current slot.
   always_comb begin
      duty_lhs = 37'(div_cnt_q) << 4;
      duty_rhs = (37'(bright) + 37'd1) * 37'(SCAN_DIV);
      duty_ok  = (duty_lhs < duty_rhs);
   end
`else
   assign duty_ok = 1'b1;
`endif

   always_comb begin
      div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
      idx_d         = idx_q;
      pend_dig_d    = pend_dig_q;
      pend_dp_d     = pend_dp_q;
      pend_blank_d  = pend_blank_q;
      shd_dig_d     = shd_dig_q;
      shd_dp_d      = shd_dp_q;
      shd_blank_d   = shd_blank_q;
      upd_pending_d = upd_pending_q;

      if (tick) begin
         idx_d = last_digit ? '0 : idx_q + 1'b1;
      end

      // A load landing on the boundary bypasses pending so it shows this frame.
      if (boundary) begin
         if (upd.load) begin
            shd_dig_d   = upd.digits_in;
            shd_dp_d    = upd.dp_in;
            shd_blank_d = upd.blank_in;
         end else if (upd_pending_q) begin
            shd_dig_d   = pend_dig_q;
            shd_dp_d    = pend_dp_q;
            shd_blank_d = pend_blank_q;
         end
         upd_pending_d = 1'b0;
      end else if (upd.load) begin
         pend_dig_d    = upd.digits_in;
         pend_dp_d     = upd.dp_in;
         pend_blank_d  = upd.blank_in;
         upd_pending_d = 1'b1;
      end
   end

   always_comb begin
      lit        = ~shd_blank_q[idx_q] & duty_ok;
      owner_hi   = (32'(idx_q) >= GROUP_U);
      seg_en_d   = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
      seg_out0_d = (lit && !owner_hi) ? dec_pat : SEG_BLANK;
      seg_out1_d = (lit &&  owner_hi) ? dec_pat : SEG_BLANK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         idx_q         <= '0;
         pend_dig_q    <= '0;
         pend_dp_q     <= '0;
         pend_blank_q  <= '1;
         shd_dig_q     <= '0;
         shd_dp_q      <= '0;
         shd_blank_q   <= '1;
         upd_pending_q <= 1'b0;
         seg_en_q      <= '0;
         seg_out0_q    <= SEG_BLANK;
         seg_out1_q    <= SEG_BLANK;
      end else begin
         div_cnt_q     <= div_cnt_d;
         idx_q         <= idx_d;
         pend_dig_q    <= pend_dig_d;
         pend_dp_q     <= pend_dp_d;
         pend_blank_q  <= pend_blank_d;
         shd_dig_q     <= shd_dig_d;
         shd_dp_q      <= shd_dp_d;
         shd_blank_q   <= shd_blank_d;
         upd_pending_q <= upd_pending_d;
         seg_en_q      <= seg_en_d;
         seg_out0_q    <= seg_out0_d;
         seg_out1_q    <= seg_out1_d;
      end
   end

   assign upd.upd_pending = upd_pending_q;
   assign frame_done      = boundary;
   assign seg_en          = seg_en_q;
   assign seg_out0        = seg_out0_q;
   assign seg_out1        = seg_out1_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl against a frame-level model
module tb_seg_scan_ctrl;

   localparam int N  = 8;
   localparam int GS = 4;
`ifdef SEG_SCAN_BRIGHTNESS_EN
   localparam int SD = 16;
`else
   localparam int SD = 4;
`endif
   localparam int FRAME = N * SD;

   logic       clk, rst_n;
   logic [3:0] bright_v;
   logic       frame_done;
   logic [7:0] seg_en, seg_out0, seg_out1;
   int         n_checks, n_pass;

   seg_scan_ctrl_if #(.NUM_DIGITS(N)) u_if ();

   seg_scan_ctrl #(.NUM_DIGITS(N), .GROUP_SIZE(GS), .SCAN_DIV(SD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd        (u_if),
`ifdef SEG_SCAN_BRIGHTNESS_EN
      .bright     (bright_v),
`endif
      .frame_done (frame_done),
      .seg_en     (seg_en),
      .seg_out0   (seg_out0),
      .seg_out1   (seg_out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   // Reference model: time since reset decides slot and frame position directly.
   int          m_cyc, m_d, m_div;
   logic        m_bnd, m_lit, m_upd;
   logic [7:0]  m_pat, exp_en, exp_o0, exp_o1;
   logic [31:0] m_pend_dig, m_shd_dig;
   logic [7:0]  m_pend_dp, m_pend_blank, m_shd_dp, m_shd_blank;
   logic [25:0] exp_vec, got_vec;

   assign m_d     = (m_cyc / SD) % N;
   assign m_div   = m_cyc % SD;
   assign m_bnd   = (m_cyc % FRAME) == FRAME - 1;
   assign m_lit   = !m_shd_blank[m_d] && (m_div * 16 < (int'(bright_v) + 1) * SD);
   assign m_pat   = hex_tab[m_shd_dig[m_d*4 +: 4]] | {7'b0, m_shd_dp[m_d]};
   assign exp_vec = {rst_n & m_bnd, m_upd, exp_en, exp_o0, exp_o1};
   assign got_vec = {frame_done, u_if.upd_pending, seg_en, seg_out0, seg_out1};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc <= 0;
         m_pend_dig <= '0; m_pend_dp <= '0; m_pend_blank <= '1;
         m_shd_dig <= '0;  m_shd_dp <= '0;  m_shd_blank <= '1;
         m_upd <= 1'b0;
         exp_en <= '0; exp_o0 <= '0; exp_o1 <= '0;
      end else begin
         exp_en <= m_lit ? 8'(1 << m_d) : 8'h00;
         exp_o0 <= (m_lit && m_d <  GS) ? m_pat : 8'h00;
         exp_o1 <= (m_lit && m_d >= GS) ? m_pat : 8'h00;
         if (m_bnd) begin
            if (u_if.load) begin
               m_shd_dig <= u_if.digits_in; m_shd_dp <= u_if.dp_in; m_shd_blank <= u_if.blank_in;
            end else if (m_upd) begin
               m_shd_dig <= m_pend_dig; m_shd_dp <= m_pend_dp; m_shd_blank <= m_pend_blank;
            end
            m_upd <= 1'b0;
         end else if (u_if.load) begin
            m_pend_dig <= u_if.digits_in; m_pend_dp <= u_if.dp_in; m_pend_blank <= u_if.blank_in;
            m_upd <= 1'b1;
         end
         m_cyc <= m_cyc + 1;
      end
   end

   task automatic set_load(input logic [31:0] dg, input logic [7:0] dp, input logic [7:0] bl);
      u_if.load = 1'b1; u_if.digits_in = dg; u_if.dp_in = dp; u_if.blank_in = bl;
   endtask

   task automatic wait_fd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         if (frame_done) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      int fd_cnt = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (got_vec !== 26'h0) $display("FAIL reset_state: got %h want %h", got_vec, 26'h0);
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         n_checks++;
         if (got_vec !== exp_vec) $display("FAIL reset_dark cyc %0d: got %h want %h", i, got_vec, exp_vec);
         else n_pass++;
         if (frame_done) fd_cnt++;
      end
      n_checks++;
      if (fd_cnt !== 3) $display("FAIL frame_done_count: got %0d want 3", fd_cnt);
      else n_pass++;
   endtask

   task automatic test_load();
      bit ok;
      int hit7 = 0;
      wait_fd(ok);
      @(negedge clk);
      set_load(32'h76543210, 8'h00, 8'h00);
      @(negedge clk);
      u_if.load = 1'b0;
      n_checks++;
      if (u_if.upd_pending !== 1'b1 || !ok) $display("FAIL load_pending: got %b want 1 (sync %0d)", u_if.upd_pending, ok);
      else n_pass++;
      for (int i = 0; i < 2 * FRAME + 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (got_vec !== exp_vec) $display("FAIL load_frame cyc %0d: got %h want %h", i, got_vec, exp_vec);
         else n_pass++;
         if (seg_en == 8'h80 && seg_out1 == 8'hE0 && seg_out0 == 8'h00) hit7++;
      end
      n_checks++;
      if (hit7 < SD) $display("FAIL load_digit7: got %0d slots want >= %0d", hit7, SD);
      else n_pass++;
   endtask

   task automatic test_last_wins();
      bit ok;
      int ones = 0, effs = 0;
      wait_fd(ok);
      @(negedge clk);
      set_load(32'h11111111, 8'h00, 8'h00);
      @(negedge clk);
      set_load(32'hFFFFFFFF, 8'h00, 8'h00);
      @(negedge clk);
      u_if.load = 1'b0;
      for (int i = 0; i < 2 * FRAME + 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (got_vec !== exp_vec) $display("FAIL last_wins cyc %0d: got %h want %h", i, got_vec, exp_vec);
         else n_pass++;
         if (!m_upd && (seg_out0 == 8'h60 || seg_out1 == 8'h60)) ones++;
         if (seg_out0 == 8'h8E || seg_out1 == 8'h8E) effs++;
      end
      n_checks++;
      if (ones !== 0 || effs < FRAME || !ok) $display("FAIL last_wins_glyphs: got ones=%0d effs=%0d want 0 and >= %0d", ones, effs, FRAME);
      else n_pass++;
   endtask

   task automatic test_same_cycle();
      bit ok;
      int ee = 0;
      wait_fd(ok);
      set_load(32'hAAAAAAAA, 8'h00, 8'h00);
      @(negedge clk);
      u_if.load = 1'b0;
      n_checks++;
      if (u_if.upd_pending !== 1'b0 || !ok) $display("FAIL same_cycle_pending: got %b want 0 (sync %0d)", u_if.upd_pending, ok);
      else n_pass++;
      for (int i = 0; i < FRAME + 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (got_vec !== exp_vec) $display("FAIL same_cycle cyc %0d: got %h want %h", i, got_vec, exp_vec);
         else n_pass++;
         if (seg_en != 0 && (seg_out0 | seg_out1) == 8'hEE) ee++;
      end
      n_checks++;
      if (ee < FRAME) $display("FAIL same_cycle_glyphs: got %0d want >= %0d", ee, FRAME);
      else n_pass++;
   endtask

   task automatic test_blank_dp();
      bit ok;
      int ff7 = 0, low_lit = 0;
      wait_fd(ok);
      @(negedge clk);
      set_load(32'h88888888, 8'h80, 8'h0F);
      @(negedge clk);
      u_if.load = 1'b0;
      for (int i = 0; i < 2 * FRAME + 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (got_vec !== exp_vec) $display("FAIL blank_dp cyc %0d: got %h want %h", i, got_vec, exp_vec);
         else n_pass++;
         if (seg_en == 8'h80 && seg_out1 == 8'hFF) ff7++;
         if (!m_upd && i > FRAME && seg_en[3:0] != 0) low_lit++;
      end
      n_checks++;
      if (ff7 < SD || low_lit !== 0 || !ok) $display("FAIL blank_dp_slots: got ff7=%0d low_lit=%0d want >= %0d and 0", ff7, low_lit, SD);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int lit = 0;
      wait_fd(ok);
      @(negedge clk);
      set_load(32'h12345678, 8'h00, 8'h00);
      @(negedge clk);
      u_if.load = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (u_if.upd_pending !== 1'b1 || !ok) $display("FAIL mid_pending: got %b want 1", u_if.upd_pending);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (got_vec !== 26'h0) $display("FAIL mid_reset_async: got %h want %h", got_vec, 26'h0);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (got_vec !== exp_vec) $display("FAIL mid_reset cyc %0d: got %h want %h", i, got_vec, exp_vec);
         else n_pass++;
         if (seg_en != 0 || seg_out0 != 0 || seg_out1 != 0) lit++;
      end
      n_checks++;
      if (lit !== 0) $display("FAIL mid_reset_dark: got %0d lit cycles want 0", lit);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 16; it++) begin
         int idle = $urandom_range(0, 2 * FRAME);
`ifdef SEG_SCAN_BRIGHTNESS_EN
         bright_v = 4'($urandom_range(0, 15));
`endif
         for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            n_checks++;
            if (got_vec !== exp_vec) $display("FAIL random it %0d cyc %0d: got %h want %h", it, i, got_vec, exp_vec);
            else n_pass++;
         end
         set_load($urandom, 8'($urandom), 8'($urandom) & 8'($urandom));
         @(negedge clk);
         n_checks++;
         if (got_vec !== exp_vec) $display("FAIL random_load it %0d: got %h want %h", it, got_vec, exp_vec);
         else n_pass++;
         u_if.load = 1'b0;
      end
      bright_v = 4'd15;
   endtask

`ifdef SEG_SCAN_BRIGHTNESS_EN
   task automatic test_brightness();
      bit ok;
      int on = 0;
      bright_v = 4'd3;
      @(negedge clk);
      set_load(32'h76543210, 8'h00, 8'h00);
      @(negedge clk);
      u_if.load = 1'b0;
      wait_fd(ok);
      @(negedge clk);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         n_checks++;
         if (got_vec !== exp_vec) $display("FAIL bright cyc %0d: got %h want %h", i, got_vec, exp_vec);
         else n_pass++;
         if (seg_en != 0) on++;
      end
      n_checks++;
      if (on !== N * 4 || !ok) $display("FAIL bright_duty: got %0d lit cycles want %0d", on, N * 4);
      else n_pass++;
      bright_v = 4'd15;
   endtask
`endif

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      bright_v = 4'd15;
      u_if.load = 1'b0; u_if.digits_in = '0; u_if.dp_in = '0; u_if.blank_in = '0;
      test_reset();
      test_load();
      test_last_wins();
      test_same_cycle();
      test_blank_dp();
      test_reset_mid();
      test_random();
`ifdef SEG_SCAN_BRIGHTNESS_EN
      test_brightness();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
